fb_scan_arbiter: RTL

FB_SCAN_ARBITER -- requirements
Module: fb_scan_arbiter

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_swap_ctl.sv | 33 +++
 rtl/fb_scan_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and arbiter state encoding.
// Also imported by the VGA timing generator.
package fb_pkg;

    localparam int unsigned ADDR_W   = 22;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned FB_WORDS = 307200;

    localparam logic [ADDR_W-1:0] FB0_BASE = '0;
    localparam logic [ADDR_W-1:0] FB1_BASE = ADDR_W'(FB_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VID_CMD = 2'd1,
        DRW_CMD = 2'd2
    } arb_state_t;

    // Physical address of a word in buffer 'sel'; the sum wraps at 22 bits.
    function automatic logic [ADDR_W-1:0] buf_addr(input logic sel,
                                                   input logic [ADDR_W-1:0] offset);
        return (sel ? FB1_BASE : FB0_BASE) + offset;
    endfunction

endpackage

// File: rtl/fb_swap_ctl.sv
// Double-buffer swap control: latches a swap request and flips the front
// buffer at the next top-of-screen pulse.
module fb_swap_ctl (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iTopOfScreen,
    input  logic iSwap_req,
    output logic oSwap_pending,
    output logic oSwap_done,
    output logic oFront
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oFront        <= 1'b0;
            oSwap_pending <= 1'b0;
            oSwap_done    <= 1'b0;
        end else begin
            oSwap_done <= 1'b0;
            // A request arriving together with top-of-screen is taken at once.
            if (iTopOfScreen && (oSwap_pending || iSwap_req)) begin
                oFront        <= ~oFront;
                oSwap_pending <= 1'b0;
                oSwap_done    <= 1'b1;
            end else if (iSwap_req) begin
                oSwap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Arbitrates scan-out reads (priority) and draw writes onto one memory port,
// mapping offsets into the front or back frame buffer.
module fb_scan_arbiter
    import fb_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iTopOfScreen,
    input  logic              iVid_req,
    input  logic [ADDR_W-1:0] iVid_offset,
    output logic              oVid_gnt,
    output logic [DATA_W-1:0] oVid_rdata,
    output logic              oVid_rvalid,
    input  logic              iDrw_req,
    input  logic [ADDR_W-1:0] iDrw_offset,
    input  logic [DATA_W-1:0] iDrw_wdata,
    output logic              oDrw_gnt,
    input  logic              iSwap_req,
    output logic              oSwap_pending,
    output logic              oSwap_done,
    output logic              oFront,
    output logic [ADDR_W-1:0] oMem_addr,
    output logic              oMem_rd,
    output logic              oMem_wr,
    output logic [DATA_W-1:0] oMem_wdata,
    input  logic              iMem_wait,
    input  logic [DATA_W-1:0] iMem_rdata,
    input  logic              iMem_rvalid
);

    arb_state_t state;

    fb_swap_ctl u_swap_ctl (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .iTopOfScreen  (iTopOfScreen),
        .iSwap_req     (iSwap_req),
        .oSwap_pending (oSwap_pending),
        .oSwap_done    (oSwap_done),
        .oFront        (oFront)
    );

    // NOTE: grants decode the registered state with the live stall input so
    // they pulse in the acceptance cycle itself, not one cycle later.
    assign oVid_gnt = (state == VID_CMD) && !iMem_wait;
    assign oDrw_gnt = (state == DRW_CMD) && !iMem_wait;

    // Base buffer is sampled here, so a later swap cannot move an issued command.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            oMem_rd    <= 1'b0;
            oMem_wr    <= 1'b0;
            oMem_addr  <= '0;
            oMem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iVid_req) begin
                        state     <= VID_CMD;
                        oMem_rd   <= 1'b1;
                        oMem_addr <= buf_addr(oFront, iVid_offset);
                    end else if (iDrw_req) begin
                        state      <= DRW_CMD;
                        oMem_wr    <= 1'b1;
                        oMem_addr  <= buf_addr(!oFront, iDrw_offset);
                        oMem_wdata <= iDrw_wdata;
                    end
                end
                VID_CMD, DRW_CMD: begin
                    if (!iMem_wait) begin
                        state   <= IDLE;
                        oMem_rd <= 1'b0;
                        oMem_wr <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    oMem_rd <= 1'b0;
                    oMem_wr <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVid_rdata  <= '0;
            oVid_rvalid <= 1'b0;
        end else begin
            oVid_rdata  <= iMem_rdata;
            oVid_rvalid <= iMem_rvalid;
        end
    end

endmodule
